// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding data-memory responder. Accepts one load/store
//            request at a time, waits a fixed number of cycles, then returns a
//            one-cycle response. The address map has a word RAM at
//            0x0000_0000, an 8-bit LED register at 0x1000_0000 and a
//            free-running 32-bit cycle counter at 0x1000_0004.
// Ports    : clk        - clock, all state changes on the rising edge
//            rst        - synchronous active-high reset
//            req_valid  - initiator presents a request
//            req_ready  - responder accepts the request this cycle
//            req_write  - 1 = store, 0 = load
//            req_addr   - byte address
//            req_wdata  - store data
//            rsp_valid  - one-cycle response strobe
//            rsp_rdata  - load data, held until the next response
//            rsp_err    - request faulted (misaligned or unmapped)
//            led        - LED register contents
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  // The down-counter is loaded with WAIT_STATES-1 so that the WAIT state
  // lasts exactly WAIT_STATES cycles (exit when the count reaches zero).
  localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [31:0] C_LED_ADDR = 32'h1000_0000;
  localparam logic [31:0] C_CNT_ADDR = 32'h1000_0004;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [3:0]  r_wcnt;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt_snap;
  logic [31:0] r_cycle;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_led;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_handshake;
  logic        w_enter_resp;
  logic        w_cur_write;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [31:0] w_cur_snap;
  logic        w_is_ram;
  logic        w_is_led;
  logic        w_is_cnt;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_load_data;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_handshake) begin
          w_state_next = (WAIT_STATES > 0) ? C_WAIT : C_RESP;
        end
      end
      C_WAIT: begin
        if (r_wcnt == 4'd0) begin
          w_state_next = C_RESP;
        end
      end
      C_RESP: begin
        w_state_next = C_IDLE;
      end
      default: begin
        w_state_next = C_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Strobes are masked by rst so that a reset cycle never
  // accepts a request or reports a response.
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = (r_state == C_IDLE) && !rst;
    rsp_valid = (r_state == C_RESP) && !rst;
    rsp_err   = (r_state == C_RESP) && !rst && r_err;
  end

  assign w_handshake  = req_valid && req_ready;
  assign w_enter_resp = (w_state_next == C_RESP) && (r_state != C_RESP) && !rst;

  // With zero wait states the RESP state is entered on the handshake edge
  // itself, before the capture registers hold the request, so the live
  // request is used while still in IDLE.
  assign w_cur_write = (r_state == C_IDLE) ? req_write : r_write;
  assign w_cur_addr  = (r_state == C_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == C_IDLE) ? req_wdata : r_wdata;
  assign w_cur_snap  = (r_state == C_IDLE) ? r_cycle   : r_cnt_snap;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_is_ram = (w_cur_addr[31:AW+2] == '0);
  assign w_is_led = (w_cur_addr == C_LED_ADDR);
  assign w_is_cnt = (w_cur_addr == C_CNT_ADDR);
  assign w_err    = (w_cur_addr[1:0] != 2'b00) || !(w_is_ram || w_is_led || w_is_cnt);
  assign w_idx    = w_cur_addr[AW+1:2];

  always_comb begin
    w_load_data = 32'h0;
    if (!w_err && !w_cur_write) begin
      if (w_is_ram) begin
        w_load_data = r_mem[w_idx];
      end else if (w_is_led) begin
        w_load_data = {24'h0, r_led};
      end else begin
        w_load_data = w_cur_snap;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt     <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_cnt_snap <= 32'h0;
      r_cycle    <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_led      <= 8'h0;
    end else begin
      // A counter store overrides the increment on the same edge.
      if (w_enter_resp && w_cur_write && w_is_cnt && !w_err) begin
        r_cycle <= 32'h0;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end

      if (w_handshake) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_cnt_snap <= r_cycle;
        r_wcnt     <= C_WAIT_LOAD;
      end else if ((r_state == C_WAIT) && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end

      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= w_load_data;
        if (w_cur_write && w_is_led && !w_err) begin
          r_led <= w_cur_wdata[7:0];
        end
      end
    end
  end

  // RAM contents survive reset; the store is suppressed during reset through
  // w_enter_resp.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_cur_write && w_is_ram && !w_err) begin
      r_mem[w_idx] <= w_cur_wdata;
    end
  end

  assign rsp_rdata = r_rdata;
  assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Stimulus pushes the
//            expected response into a queue; a monitor pops and compares on
//            every response strobe. Two instances: WAIT_STATES=2 and 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  led;

  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic        rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [7:0]  led0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .led(led)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .led(led0)
  );

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
    bit          chk_led;
    logic [7:0]  led;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb0_q[$];
  exp_t mon_e, mon0_e;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rsp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitors
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_latency", 32'(cyc), 32'(mon_e.due));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        if (mon_e.chk_rdata) check("rsp_rdata", rsp_rdata, mon_e.rdata);
        if (mon_e.chk_led) check("led_at_resp", 32'(led), 32'(mon_e.led));
      end
    end else if (rsp_err !== 1'b0) begin
      check("rsp_err_outside_resp", 32'(rsp_err), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (rsp_valid0 === 1'b1) begin
      if (sb0_q.size() == 0) begin
        check("unexpected_rsp0", 32'(rsp_valid0), 32'd0);
      end else begin
        mon0_e = sb0_q.pop_front();
        check("rsp0_latency", 32'(cyc), 32'(mon0_e.due));
        check("rsp0_err", 32'(rsp_err0), 32'(mon0_e.err));
        if (mon0_e.chk_rdata) check("rsp0_rdata", rsp_rdata0, mon0_e.rdata);
        if (mon0_e.chk_led) check("led0_at_resp", 32'(led0), 32'(mon0_e.led));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Presents one request to the WAIT_STATES=2 instance starting at a negedge;
  // the response is expected 3 cycles after the handshake cycle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input bit chk_rd, input logic [31:0] rd,
                       input bit chk_led, input logic [7:0] exp_led);
    exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("handshake_timeout", 32'(req_ready), 32'd1);
    end else begin
      e.due       = cyc + 3;
      e.rdata     = rd;
      e.err       = err;
      e.chk_rdata = chk_rd;
      e.chk_led   = chk_led;
      e.led       = exp_led;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble the request lines; the captured transaction must not notice.
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = addr ^ 32'hFFFF_FFFC;
    req_wdata = ~wdata;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || sb0_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    if (sb0_q.size() != 0) check("drain0_timeout", 32'(sb0_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int rsp_before;
    exp_t e0;
    logic exp_ready;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state, including ready held low while rst is high.
    req_valid = 1'b1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_req_ready0", 32'(req_ready0), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_led", 32'(led), 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // RAM store/load.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h0);
    issue(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0);
    issue(1'b1, 32'h3FC, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0);
    issue(1'b0, 32'h3FC, 32'h0, 1'b0, 1'b1, 32'h0BAD_C0DE, 1'b0, 8'h0);
    drain();
    check("rdata_held", rsp_rdata, 32'h0BAD_C0DE);
    issue(1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 8'h0);

    // LED register.
    check("led_before_write", 32'(led), 32'h0);
    issue(1'b1, 32'h1000_0000, 32'h0000_01A5, 1'b0, 1'b0, 32'h0, 1'b1, 8'hA5);
    issue(1'b0, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'h0);

    // Errors modify nothing.
    issue(1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 8'hA5);
    issue(1'b1, 32'h2000_0000, 32'h77, 1'b1, 1'b1, 32'h0, 1'b1, 8'hA5);
    issue(1'b1, 32'h11, 32'h5555_5555, 1'b1, 1'b1, 32'h0, 1'b0, 8'h0);
    issue(1'b1, 32'h1000_0001, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 8'hA5);
    issue(1'b0, 32'h1000_0008, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 8'h0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'hA5);
    drain();

    // Counter store clears it on the RESP edge, so it reads 0 during the RESP
    // cycle; a load handshaked at the end of the 5th cycle after that returns 5.
    issue(1'b1, 32'h1000_0004, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 20);
    check("counter_store_rsp", 32'(rsp_valid), 32'd1);
    repeat (4) @(negedge clk);
    issue(1'b0, 32'h1000_0004, 32'h0, 1'b0, 1'b1, 32'd5, 1'b0, 8'h0);
    drain();

    // Counter wrap: all-ones becomes 0 on the following edge, which is the
    // value sampled by the handshake one edge later.
    @(negedge clk);
    force u_dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release u_dut.r_cycle;
    issue(1'b0, 32'h1000_0004, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h0);
    drain();

    // Reset during WAIT abandons a store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000_1234;
    check("rst_case_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    rsp_before = rsp_seen;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_rsp", 32'(rsp_seen - rsp_before), 32'd0);
    check("rst_led_cleared", 32'(led), 32'h0);
    issue(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h0);
    issue(1'b0, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h0);
    drain();

    // WAIT_STATES=0 instance: one LED store, then held-high back-to-back loads.
    @(negedge clk);
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h1000_0000; req_wdata0 = 32'h0000_003C;
    check("ws0_ready", 32'(req_ready0), 32'd1);
    e0.due = cyc + 1; e0.rdata = 32'h0; e0.err = 1'b0;
    e0.chk_rdata = 1'b0; e0.chk_led = 1'b1; e0.led = 8'h3C;
    sb0_q.push_back(e0);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h1000_0000; req_wdata0 = 32'h0;
    for (int k = 0; k < 10; k++) begin
      exp_ready = ((k % 2) == 0);
      check("ws0_ready_pattern", 32'(req_ready0), 32'(exp_ready));
      if (req_ready0 === 1'b1) begin
        e0.due = cyc + 1; e0.rdata = 32'h0000_003C; e0.err = 1'b0;
        e0.chk_rdata = 1'b1; e0.chk_led = 1'b0; e0.led = 8'h0;
        sb0_q.push_back(e0);
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("sb0_empty", 32'(sb0_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit RAM words (power of two, 16..1024).
REQ-002 SHALL have parameter WAIT_STATES, default 2, cycles inserted between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  output  32  load data, valid while rsp_valid=1.
REQ-012 SHALL have port rsp_err  output  1  request faulted, valid while rsp_valid=1.
REQ-013 SHALL have port led  output  8  LED register contents.

Function
REQ-014 SHALL map addresses 0x0000_0000..(4*DEPTH_WORDS-1) to RAM, 0x1000_0000 to LED register, 0x1000_0004 to cycle counter; all other addresses are unmapped.
REQ-015 SHALL use FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a handshake occurs when req_valid=1 and req_ready=1 at posedge clk.
REQ-017 SHALL capture req_write, req_addr and req_wdata at the handshake edge; later input changes have no effect on that transaction.
REQ-018 SHALL move from IDLE to WAIT on handshake when WAIT_STATES>0, or directly to RESP when WAIT_STATES=0.
REQ-019 SHALL stay in WAIT for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then enter RESP.
REQ-020 SHALL assert rsp_valid for exactly one cycle, the RESP cycle, and return to IDLE on the next edge.
REQ-021 SHALL place the RESP cycle WAIT_STATES+1 cycles after the handshake edge; minimum request spacing is WAIT_STATES+2 cycles.
REQ-022 SHALL flag misaligned addresses (addr[1:0] != 0) and unmapped addresses as errors.
REQ-023 SHALL, on an error, return rsp_err=1 and rsp_rdata=0 and modify no state.
REQ-024 SHALL index RAM by addr[log2(DEPTH_WORDS)+1:2].
REQ-025 SHALL commit stores on the edge that enters RESP.
REQ-026 SHALL load rsp_rdata on the edge that enters RESP and hold it until the next response.
REQ-027 SHALL, on a LED write, load led <= wdata[7:0]; a LED read returns {24'h0, led}.
REQ-028 SHALL increment the cycle counter every cycle; it is 32-bit and wraps 0xFFFF_FFFF -> 0.
REQ-029 SHALL, on a counter read, return the counter value sampled at the handshake edge.
REQ-030 SHALL, on a counter write, clear the counter to 0; a counter write that coincides with an increment is resolved as clear.
REQ-031 SHALL drive rsp_valid=0 and rsp_err=0 outside RESP.
REQ-032 SHALL ignore req_valid outside IDLE; no queueing.

Reset
REQ-033 SHALL, while rst=1 at posedge clk, force state=IDLE, wait counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, led=0, cycle counter=0.
REQ-034 SHALL keep req_ready=0 during any cycle in which rst=1.
REQ-035 SHALL NOT clear RAM contents on reset.
REQ-036 SHALL, if rst is asserted in WAIT or RESP, abandon the transaction: no store commit and no response strobe.

Verification
REQ-037 SHALL cover RAM store/load (WAIT_STATES=2): store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_valid 3 cycles after each handshake, rdata=0xDEADBEEF, rsp_err=0.
REQ-038 SHALL cover LED write: store 0x0000_01A5 to 0x1000_0000 -> led=0xA5 from the RESP edge; load of the same address returns 0x0000_00A5.
REQ-039 SHALL cover errors: load 0x0000_0012 and store to 0x2000_0000 -> rsp_err=1, rdata=0; RAM word 0x10 and led unchanged.
REQ-040 SHALL cover the counter: store any value to 0x1000_0004, then load it 5 cycles later -> returns 5; force counter to 0xFFFF_FFFF -> wraps to 0 on the next cycle.
REQ-041 SHALL cover reset mid-operation: handshake a store of 0x1234 to 0x20, assert rst for one cycle during WAIT -> no rsp_valid; later load 0x20 returns the prior contents; led=0.
REQ-042 SHALL cover WAIT_STATES=0 back-to-back traffic: req_valid held high -> req_ready pulses every 2nd cycle and rsp_valid the cycle after each handshake.
